// File: rtl/axis_tg_pkg.sv
// Shared types and helpers for the AXI-Stream traffic generator.
package axis_tg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_FIN  = 2'd2
  } tg_state_e;

  // tdata is split into a packet-index half and a beat-index half
  function automatic int half_width(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/axis_tg_dest_seq.sv
// Destination sequencer: holds the current packet destination and steps it
// round-robin across endpoints, skipping the local endpoint.
module axis_tg_dest_seq
  import axis_tg_pkg::*;
#(
  parameter int TDEST_WIDTH   = 4,
  parameter int NUM_ENDPOINTS = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic                   advance_i,
  input  logic                   rr_mode_i,
  input  logic [TDEST_WIDTH-1:0] fixed_dest_i,
  input  logic [TDEST_WIDTH-1:0] self_addr_i,
  output logic [TDEST_WIDTH-1:0] dest_o
);

  localparam logic [TDEST_WIDTH:0] NUM_EP  = (TDEST_WIDTH+1)'(NUM_ENDPOINTS);
  localparam logic                 SKIP_EN = (NUM_ENDPOINTS > 1);

  logic                   rr_q,   rr_d;
  logic [TDEST_WIDTH-1:0] dest_q, dest_d;
  logic [TDEST_WIDTH-1:0] step_s;

  function automatic logic [TDEST_WIDTH-1:0] wrap_inc(input logic [TDEST_WIDTH-1:0] d);
    logic [TDEST_WIDTH:0] sum;
    sum = {1'b0, d} + {{TDEST_WIDTH{1'b0}}, 1'b1};
    return TDEST_WIDTH'(sum % NUM_EP);
  endfunction

  always_comb begin
    rr_d   = rr_q;
    dest_d = dest_q;
    step_s = wrap_inc(dest_q);
    if (load_i) begin
      rr_d = rr_mode_i;
      if (rr_mode_i && SKIP_EN && (fixed_dest_i == self_addr_i)) begin
        dest_d = wrap_inc(fixed_dest_i);
      end else begin
        dest_d = fixed_dest_i;
      end
    end else if (advance_i && rr_q) begin
      // a single extra step is enough: two consecutive values cannot both be self
      if (SKIP_EN && (step_s == self_addr_i)) begin
        dest_d = wrap_inc(step_s);
      end else begin
        dest_d = step_s;
      end
    end else begin
      dest_d = dest_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q   <= 1'b0;
      dest_q <= '0;
    end else begin
      rr_q   <= rr_d;
      dest_q <= dest_d;
    end
  end

  assign dest_o = dest_q;

endmodule

// File: rtl/axis_traffic_gen.sv
// AXI-Stream packet generator: on start, emits a configured number of
// fixed-length packets with an index-encoded payload, then pulses done.
module axis_traffic_gen
  import axis_tg_pkg::*;
#(
  parameter int TDATA_WIDTH       = 32,
  parameter int TDEST_WIDTH       = 4,
  parameter int TID_WIDTH         = 2,
  parameter int NOC_NUM_ENDPOINTS = 4,
  parameter int PKT_LEN_WIDTH     = 8,
  parameter int PKT_CNT_WIDTH     = 16
) (
  input  logic                     clk_usr,
  input  logic                     rst_usr_sync,
  input  logic                     start,
  input  logic [PKT_LEN_WIDTH-1:0] cfg_pkt_len,
  input  logic [PKT_CNT_WIDTH-1:0] cfg_num_pkts,
  input  logic                     cfg_rr_mode,
  input  logic [TDEST_WIDTH-1:0]   cfg_fixed_dest,
  input  logic [TID_WIDTH-1:0]     cfg_tid,
  input  logic [TDEST_WIDTH-1:0]   self_addr,
  output logic                     busy,
  output logic                     done,
  output logic [PKT_CNT_WIDTH-1:0] pkts_sent,
  output logic                     axis_out_tvalid,
  input  logic                     axis_out_tready,
  output logic [TDATA_WIDTH-1:0]   axis_out_tdata,
  output logic                     axis_out_tlast,
  output logic [TID_WIDTH-1:0]     axis_out_tid,
  output logic [TDEST_WIDTH-1:0]   axis_out_tdest
);

  localparam int HALF_W = half_width(TDATA_WIDTH);

  tg_state_e                state_q,     state_d;
  logic [PKT_LEN_WIDTH-1:0] beat_q,      beat_d;
  logic [PKT_LEN_WIDTH-1:0] last_beat_q, last_beat_d;
  logic [PKT_CNT_WIDTH-1:0] pkt_q,       pkt_d;
  logic [PKT_CNT_WIDTH-1:0] last_pkt_q,  last_pkt_d;
  logic [PKT_CNT_WIDTH-1:0] sent_q,      sent_d;
  logic [TID_WIDTH-1:0]     tid_q,       tid_d;
  logic                     valid_q;
  logic                     done_q;
  logic                     load_s;
  logic                     adv_s;
  logic                     hs_s;
  logic [TDEST_WIDTH-1:0]   dest_s;

  assign hs_s = valid_q & axis_out_tready;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    last_beat_d = last_beat_q;
    pkt_d       = pkt_q;
    last_pkt_d  = last_pkt_q;
    sent_d      = sent_q;
    tid_d       = tid_q;
    load_s      = 1'b0;
    adv_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_s      = 1'b1;
          beat_d      = '0;
          pkt_d       = '0;
          sent_d      = '0;
          tid_d       = cfg_tid;
          // a zero length is treated as a single-beat packet
          if (cfg_pkt_len == '0) begin
            last_beat_d = '0;
          end else begin
            last_beat_d = cfg_pkt_len - PKT_LEN_WIDTH'(1);
          end
          last_pkt_d = cfg_num_pkts - PKT_CNT_WIDTH'(1);
          if (cfg_num_pkts == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (hs_s) begin
          if (beat_q == last_beat_q) begin
            beat_d = '0;
            sent_d = sent_q + PKT_CNT_WIDTH'(1);
            if (pkt_q == last_pkt_q) begin
              state_d = ST_FIN;
            end else begin
              pkt_d = pkt_q + PKT_CNT_WIDTH'(1);
              adv_s = 1'b1;
            end
          end else begin
            beat_d = beat_q + PKT_LEN_WIDTH'(1);
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_usr) begin
    if (rst_usr_sync) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      last_beat_q <= '0;
      pkt_q       <= '0;
      last_pkt_q  <= '0;
      sent_q      <= '0;
      tid_q       <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_beat_q <= last_beat_d;
      pkt_q       <= pkt_d;
      last_pkt_q  <= last_pkt_d;
      sent_q      <= sent_d;
      tid_q       <= tid_d;
      valid_q     <= (state_d == ST_SEND);
      done_q      <= (state_d == ST_FIN);
    end
  end

  axis_tg_dest_seq #(
    .TDEST_WIDTH   (TDEST_WIDTH),
    .NUM_ENDPOINTS (NOC_NUM_ENDPOINTS)
  ) u_dest_seq (
    .clk_i        (clk_usr),
    .rst_i        (rst_usr_sync),
    .load_i       (load_s),
    .advance_i    (adv_s),
    .rr_mode_i    (cfg_rr_mode),
    .fixed_dest_i (cfg_fixed_dest),
    .self_addr_i  (self_addr),
    .dest_o       (dest_s)
  );

  assign busy            = valid_q;
  assign done            = done_q;
  assign pkts_sent       = sent_q;
  assign axis_out_tvalid = valid_q;
  assign axis_out_tdata  = {HALF_W'(pkt_q), HALF_W'(beat_q)};
  assign axis_out_tlast  = valid_q & (beat_q == last_beat_q);
  assign axis_out_tid    = tid_q;
  assign axis_out_tdest  = dest_s;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Self-checking bench for axis_traffic_gen: a beat-list reference model plus
// directed and randomized runs.
module tb_axis_traffic_gen;

  localparam int DW   = 32;
  localparam int DSTW = 4;
  localparam int TIDW = 2;
  localparam int NEP  = 4;
  localparam int LW   = 8;
  localparam int CW   = 16;

  logic            clk_usr = 1'b0;
  logic            rst_usr_sync;
  logic            start;
  logic [LW-1:0]   cfg_pkt_len;
  logic [CW-1:0]   cfg_num_pkts;
  logic            cfg_rr_mode;
  logic [DSTW-1:0] cfg_fixed_dest;
  logic [TIDW-1:0] cfg_tid;
  logic [DSTW-1:0] self_addr;
  logic            busy, done;
  logic [CW-1:0]   pkts_sent;
  logic            axis_out_tvalid, axis_out_tready, axis_out_tlast;
  logic [DW-1:0]   axis_out_tdata;
  logic [TIDW-1:0] axis_out_tid;
  logic [DSTW-1:0] axis_out_tdest;

  always #5 clk_usr = ~clk_usr;

  axis_traffic_gen #(
    .TDATA_WIDTH(DW), .TDEST_WIDTH(DSTW), .TID_WIDTH(TIDW),
    .NOC_NUM_ENDPOINTS(NEP), .PKT_LEN_WIDTH(LW), .PKT_CNT_WIDTH(CW)
  ) dut (
    .clk_usr(clk_usr), .rst_usr_sync(rst_usr_sync), .start(start),
    .cfg_pkt_len(cfg_pkt_len), .cfg_num_pkts(cfg_num_pkts), .cfg_rr_mode(cfg_rr_mode),
    .cfg_fixed_dest(cfg_fixed_dest), .cfg_tid(cfg_tid), .self_addr(self_addr),
    .busy(busy), .done(done), .pkts_sent(pkts_sent),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tlast(axis_out_tlast),
    .axis_out_tid(axis_out_tid), .axis_out_tdest(axis_out_tdest)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the whole run is expanded into a list of expected beats
  typedef struct {
    logic [DW-1:0]   data;
    logic            last;
    logic [DSTW-1:0] dest;
    logic [TIDW-1:0] tid;
  } beat_t;

  beat_t exp_q[$];
  bit    m_run  = 1'b0;
  bit    m_fin  = 1'b0;
  bit    m_init = 1'b0;
  int    m_sent = 0;

  logic [DW-1:0]   obs_data[$];
  logic            obs_last[$];
  logic [DSTW-1:0] obs_dest[$];
  int              valid_cycles;
  bit              busy_seen;

  task automatic build_run();
    int len, num, d;
    beat_t bt;
    len = (cfg_pkt_len == 0) ? 1 : int'(cfg_pkt_len);
    num = int'(cfg_num_pkts);
    d   = int'(cfg_fixed_dest);
    if (cfg_rr_mode) begin
      while (NEP > 1 && d == int'(self_addr)) d = (d + 1) % NEP;
    end
    for (int p = 0; p < num; p++) begin
      if (p > 0 && cfg_rr_mode) begin
        d = (d + 1) % NEP;
        while (NEP > 1 && d == int'(self_addr)) d = (d + 1) % NEP;
      end
      for (int b = 0; b < len; b++) begin
        bt.data = 32'((p % 65536) * 65536 + b);
        bt.last = (b == len - 1);
        bt.dest = DSTW'(d);
        bt.tid  = cfg_tid;
        exp_q.push_back(bt);
      end
    end
  endtask

  task automatic model_step();
    beat_t bt;
    if (rst_usr_sync) begin
      exp_q.delete();
      m_run  = 1'b0;
      m_fin  = 1'b0;
      m_sent = 0;
      m_init = 1'b1;
    end else if (m_fin) begin
      m_fin = 1'b0;
    end else if (m_run) begin
      if (axis_out_tready) begin
        bt = exp_q.pop_front();
        if (bt.last) m_sent++;
        if (exp_q.size() == 0) begin
          m_run = 1'b0;
          m_fin = 1'b1;
        end
      end
    end else if (start) begin
      build_run();
      m_sent = 0;
      if (exp_q.size() == 0) m_fin = 1'b1;
      else m_run = 1'b1;
    end
  endtask

  task automatic compare_step();
    if (!m_init) return;
    check("tvalid",    64'(axis_out_tvalid), 64'(m_run));
    check("busy",      64'(busy),            64'(m_run));
    check("done",      64'(done),            64'(m_fin));
    check("pkts_sent", 64'(pkts_sent),       64'(m_sent));
    if (m_run && exp_q.size() > 0) begin
      check("tdata", 64'(axis_out_tdata), 64'(exp_q[0].data));
      check("tlast", 64'(axis_out_tlast), 64'(exp_q[0].last));
      check("tdest", 64'(axis_out_tdest), 64'(exp_q[0].dest));
      check("tid",   64'(axis_out_tid),   64'(exp_q[0].tid));
    end
    if (axis_out_tvalid) valid_cycles++;
    if (busy) busy_seen = 1'b1;
    if (axis_out_tvalid && axis_out_tready) begin
      obs_data.push_back(axis_out_tdata);
      obs_last.push_back(axis_out_tlast);
      obs_dest.push_back(axis_out_tdest);
    end
  endtask

  initial forever begin
    @(posedge clk_usr);
    model_step();
  end

  initial forever begin
    @(negedge clk_usr);
    compare_step();
  end

  task automatic clear_logs();
    obs_data.delete();
    obs_last.delete();
    obs_dest.delete();
    valid_cycles = 0;
    busy_seen    = 1'b0;
  endtask

  task automatic set_cfg(input int len, input int num, input bit rr, input int fd, input int tid);
    cfg_pkt_len    = LW'(len);
    cfg_num_pkts   = CW'(num);
    cfg_rr_mode    = rr;
    cfg_fixed_dest = DSTW'(fd);
    cfg_tid        = TIDW'(tid);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk_usr); #1;
    start = 1'b0;
  endtask

  // mode 0: tready held high; 1: random tready and stray starts; 2: tready toggles from 0
  task automatic wait_done(input int mode);
    int i;
    axis_out_tready = (mode == 2) ? 1'b0 : 1'b1;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk_usr);
      if (done) break;
      @(posedge clk_usr); #1;
      case (mode)
        1: begin
          axis_out_tready = ($urandom_range(0, 2) != 0);
          start = ($urandom_range(0, 7) == 0);
          set_cfg($urandom_range(0, 6), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end
        2: axis_out_tready = ~axis_out_tready;
        default: axis_out_tready = 1'b1;
      endcase
    end
    check("done_timeout", 64'(done), 64'(1));
    @(posedge clk_usr); #1;
    start = 1'b0;
  endtask

  task automatic run(input int len, input int num, input bit rr, input int fd, input int tid, input int mode);
    set_cfg(len, num, rr, fd, tid);
    clear_logs();
    pulse_start();
    wait_done(mode);
  endtask

  function automatic logic [63:0] obs_d(input int i);
    return (i < obs_data.size()) ? 64'(obs_data[i]) : 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  logic [31:0] lit_data1 [6] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002,
                                 32'h0001_0000, 32'h0001_0001, 32'h0001_0002};
  logic        lit_last1 [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [3:0]  lit_dest2 [4] = '{4'd0, 4'd2, 4'd3, 4'd0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_usr_sync    = 1'b1;
    start           = 1'b0;
    axis_out_tready = 1'b0;
    self_addr       = 4'd1;
    set_cfg(0, 0, 1'b0, 0, 0);
    clear_logs();
    repeat (3) @(posedge clk_usr);
    #1 rst_usr_sync = 1'b0;

    @(negedge clk_usr);
    check("rst_tvalid", 64'(axis_out_tvalid), 64'(0));
    check("rst_busy",   64'(busy),            64'(0));
    check("rst_done",   64'(done),            64'(0));
    check("rst_sent",   64'(pkts_sent),       64'(0));
    check("rst_tdata",  64'(axis_out_tdata),  64'(0));
    check("rst_tlast",  64'(axis_out_tlast),  64'(0));
    check("rst_tdest",  64'(axis_out_tdest),  64'(0));
    check("rst_tid",    64'(axis_out_tid),    64'(0));
    @(posedge clk_usr); #1;

    // Fixed destination, two 3-beat packets
    run(3, 2, 1'b0, 5, 1, 0);
    check("t1_beats", 64'(obs_data.size()), 64'(6));
    for (int i = 0; i < 6; i++) begin
      check("t1_data", obs_d(i), 64'(lit_data1[i]));
      check("t1_last", (i < obs_last.size()) ? 64'(obs_last[i]) : 64'hF, 64'(lit_last1[i]));
    end
    check("t1_sent", 64'(pkts_sent), 64'(2));
    check("t1_dest", (obs_dest.size() > 0) ? 64'(obs_dest[0]) : 64'hF, 64'(5));

    // Round-robin skipping self endpoint 1
    self_addr = 4'd1;
    run(1, 4, 1'b1, 0, 2, 0);
    for (int i = 0; i < 4; i++)
      check("t2_dest", (i < obs_dest.size()) ? 64'(obs_dest[i]) : 64'hF, 64'(lit_dest2[i]));

    // Alternating tready: 4 beats over 8 valid cycles
    run(4, 1, 1'b0, 3, 0, 2);
    check("t3_valid_cycles", 64'(valid_cycles), 64'(8));
    check("t3_beats", 64'(obs_data.size()), 64'(4));
    for (int i = 0; i < 4; i++) check("t3_data", obs_d(i), 64'(i));

    // Empty run
    run(5, 0, 1'b0, 2, 0, 0);
    check("t4_valid_cycles", 64'(valid_cycles), 64'(0));
    check("t4_busy_seen", 64'(busy_seen), 64'(0));

    // Second start during a run must be ignored
    axis_out_tready = 1'b1;
    set_cfg(2, 3, 1'b0, 2, 3);
    clear_logs();
    pulse_start();
    set_cfg(7, 1, 1'b1, 9, 0);
    pulse_start();
    wait_done(0);
    check("t5_sent", 64'(pkts_sent), 64'(3));
    check("t5_beats", 64'(obs_data.size()), 64'(6));
    check("t5_dest", (obs_dest.size() > 5) ? 64'(obs_dest[5]) : 64'hF, 64'(2));

    // Reset while beat 2 of 4 is presented, then a fresh run
    axis_out_tready = 1'b1;
    set_cfg(4, 2, 1'b0, 6, 1);
    clear_logs();
    pulse_start();
    @(posedge clk_usr); #1;
    @(posedge clk_usr); #1;
    rst_usr_sync    = 1'b1;
    axis_out_tready = 1'b0;
    @(posedge clk_usr); #1;
    rst_usr_sync = 1'b0;
    @(negedge clk_usr);
    check("t6_tvalid", 64'(axis_out_tvalid), 64'(0));
    check("t6_busy",   64'(busy),            64'(0));
    check("t6_sent",   64'(pkts_sent),       64'(0));
    @(posedge clk_usr); #1;
    run(4, 2, 1'b0, 6, 1, 0);
    check("t6_first", obs_d(0), 64'h0000_0000);
    check("t6_pkt1",  obs_d(4), 64'h0001_0000);
    check("t6_done_sent", 64'(pkts_sent), 64'(2));

    // Randomized runs with random backpressure and stray starts
    for (int k = 0; k < 30; k++) begin
      self_addr = DSTW'($urandom_range(0, 3));
      run($urandom_range(0, 5), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
          $urandom_range(0, 3), $urandom_range(0, 3), 1);
      repeat ($urandom_range(0, 2)) @(posedge clk_usr);
      #1;
    end

    repeat (3) @(posedge clk_usr);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_traffic_gen.md
Name: axis_traffic_gen

Overview:
AXI-Stream packet generator that drives a router_wrap injection port (axis_in_*) in user-clock domain for NoC bring-up and bandwidth characterisation. On a start pulse it emits a configured number of fixed-length packets with self-checking payload. Destination is either fixed or round-robin across endpoints, skipping the local endpoint. It also reports progress and completion.

Parameters:
TDATA_WIDTH, 32, payload width; must be even and >= 16
TDEST_WIDTH, 4, destination endpoint field width
TID_WIDTH, 2, tid field width
NOC_NUM_ENDPOINTS, 4, round-robin wrap point (destinations 0..NOC_NUM_ENDPOINTS-1)
PKT_LEN_WIDTH, 8, width of beats-per-packet config
PKT_CNT_WIDTH, 16, width of packet-count config and counter

Ports:
clk_usr  in  1  user clock
rst_usr_sync  in  1  synchronous active-high reset
start  in  1  1-cycle pulse; latches cfg_* and begins run (ignored while busy)
cfg_pkt_len  in  PKT_LEN_WIDTH  beats per packet; 0 treated as 1
cfg_num_pkts  in  PKT_CNT_WIDTH  packets in run; 0 = empty run
cfg_rr_mode  in  1  0 = fixed dest, 1 = round-robin dest
cfg_fixed_dest  in  TDEST_WIDTH  dest in fixed mode; first candidate in RR mode
cfg_tid  in  TID_WIDTH  tid for all beats of run
self_addr  in  TDEST_WIDTH  local endpoint; skipped in RR mode
busy  out  1  run in progress
done  out  1  1-cycle completion pulse
pkts_sent  out  PKT_CNT_WIDTH  packets completed in current/last run
axis_out_tvalid  out  1  AXIS valid
axis_out_tready  in  1  AXIS ready
axis_out_tdata  out  TDATA_WIDTH  payload
axis_out_tlast  out  1  last beat of packet
axis_out_tid  out  TID_WIDTH  latched cfg_tid
axis_out_tdest  out  TDEST_WIDTH  current packet destination

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-packet drops tvalid at next edge, no tlast completion; downstream must tolerate truncated packet (bring-up only).
- States: IDLE, SEND, FIN.
- IDLE: start=1 -> latch cfg; pkts_sent<=0. If cfg_num_pkts==0 -> FIN, else SEND with beat_idx=0, pkt_idx=0, dest = first valid dest.
- SEND: tvalid=1, busy=1. Handshake = tvalid&tready. On handshake: beat_idx++; if beat_idx==len-1 (tlast beat): pkts_sent++, beat_idx<=0; if pkt_idx==num_pkts-1 -> FIN else pkt_idx++, dest advances. No idle cycle between packets.
- FIN: done=1, busy=0, tvalid=0 for one cycle -> IDLE. start in FIN ignored.
- Latency: start at edge N -> tvalid high in cycle N+1. Final handshake at edge M -> done high in cycle M+1.
- AXIS rule: while tvalid && !tready, tdata/tlast/tdest/tid held stable; tvalid never deasserts without handshake except by reset.
- tdata = {pkt_idx[TDATA_WIDTH/2-1:0], beat_idx zero-extended to TDATA_WIDTH/2}; pkt_idx truncated if wider.
- tlast = (beat_idx == effective_len-1); len 1 -> every beat tlast.
- Destination: fixed mode -> cfg_fixed_dest every packet, self_addr not skipped. RR mode -> first dest = cfg_fixed_dest, advanced if ==self_addr; next = (d+1) mod NOC_NUM_ENDPOINTS, repeated once more if ==self_addr. If NOC_NUM_ENDPOINTS==1, no skipping.
- pkts_sent holds final value after run until next accepted start.
- start and cfg changes while busy have no effect on run in progress.

Decomposition:
- Package axis_tg_pkg: state enum (IDLE, SEND, FIN), tdata split constant (TDATA_WIDTH/2 helper function).
- Sub-module axis_tg_dest_seq: holds current dest; inputs load/advance/rr_mode/fixed_dest/self_addr; performs mod-wrap and self-skip combinationally on the next value.

Test Plan:
- len=3, num=2, fixed dest 5, tready=1 -> 6 beats with tdata 0x00000000, 0x00000001, 0x00000002, 0x00010000, 0x00010001, 0x00010002; tlast on beats 3 and 6; done one cycle after beat 6; pkts_sent=2.
- RR mode, fixed_dest=0, self_addr=1, 4 endpoints, num=4, len=1 -> tdest 0, 2, 3, 0.
- tready toggled 1010..., len=4 -> payload stable during stalls, no beat dropped or duplicated, 4 beats in 8 cycles.
- num_pkts=0 -> no tvalid; done pulses cycle after start+1; busy never high.
- Second start during SEND with different cfg -> ignored; run completes with original config.
- Reset asserted mid-packet (beat 2 of 4) -> tvalid, busy, and pkts_sent 0 next cycle; new start -> run restarts from pkt 0 beat 0.
